// File: rtl/eq_pkg.sv
// eq_pkg: shared widths and types for the I2S receiver and the equalizer filter bank
package eq_pkg;
    localparam int I2S_DATA_W = 24;
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an async input with a registered rising-edge strobe
module sync_edge_det #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic              prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
        end
    end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: I2S receiver producing left/right PCM pairs with valid and frame-error strobes
module i2s_rx_deserializer import eq_pkg::*; #(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SYNC_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I2S_sclk,
    input  logic              I2S_ws,
    input  logic              I2S_data,
    output logic [DATA_W-1:0] lft_chnnl,
    output logic [DATA_W-1:0] rght_chnnl,
    output logic              vld,
    output logic              frm_err
);
    localparam int CW = $clog2(DATA_W + 1);
    logic              sclk_rise;
    logic [SYNC_STAGES:0] ws_sync, data_sync;
    i2s_state_t        state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] lft_shft, rght_shft;
    logic              ws_prev, ws, dat, ws_fall, ws_rise, full;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (I2S_sclk),
        .rise (sclk_rise)
    );

    // one stage deeper than the sclk chain to match the registered edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_sync   <= '0;
            data_sync <= '0;
        end else begin
            ws_sync   <= {ws_sync[SYNC_STAGES-1:0], I2S_ws};
            data_sync <= {data_sync[SYNC_STAGES-1:0], I2S_data};
        end
    end

    assign ws      = ws_sync[SYNC_STAGES];
    assign dat     = data_sync[SYNC_STAGES];
    assign ws_fall = ws_prev & ~ws;
    assign ws_rise = ~ws_prev & ws;
    assign full    = bit_cnt == CW'(DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            bit_cnt    <= '0;
            lft_shft   <= '0;
            rght_shft  <= '0;
            ws_prev    <= 1'b0;
            lft_chnnl  <= '0;
            rght_chnnl <= '0;
            vld        <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            vld     <= 1'b0;
            frm_err <= 1'b0;
            if (sclk_rise) begin
                ws_prev <= ws;
                case (state)
                    SYNC: if (ws_fall) begin
                        state   <= LEFT;
                        bit_cnt <= '0;
                    end
                    LEFT: if (ws_rise) begin
                        bit_cnt <= '0;
                        state   <= full ? RIGHT : SYNC;
                        frm_err <= ~full;
                    end else if (ws_fall) begin
                        bit_cnt <= '0;
                        frm_err <= 1'b1;
                    end else if (!full) begin
                        lft_shft <= {lft_shft[DATA_W-2:0], dat};
                        bit_cnt  <= bit_cnt + CW'(1);
                    end
                    RIGHT: if (ws_fall) begin
                        bit_cnt <= '0;
                        state   <= LEFT;
                        if (full) begin
                            lft_chnnl  <= lft_shft;
                            rght_chnnl <= rght_shft;
                            vld        <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else if (!full) begin
                        rght_shft <= {rght_shft[DATA_W-2:0], dat};
                        bit_cnt   <= bit_cnt + CW'(1);
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end
endmodule
